// File: rtl/cic_decimator_param_if.sv
// Sample/handshake bundle for the parametrised CIC decimator: rate and
// rounding controls, the input sample strobe, and the valid/ready output.
interface cic_decimator_param_if #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int RATE_W = 6
);
    logic        [RATE_W-1:0] cic_rate;
    logic                     cic_round;
    logic                     cic_din_valid;
    logic signed [IN_W-1:0]   cic_din;
    logic                     cic_dout_valid;
    logic                     cic_dout_ready;
    logic signed [OUT_W-1:0]  cic_dout;
    logic                     cic_ovf;

    // Upstream/downstream side: drives samples and controls, consumes output.
    modport master (
        output cic_rate, cic_round, cic_din_valid, cic_din, cic_dout_ready,
        input  cic_dout_valid, cic_dout, cic_ovf
    );

    // Decimator side.
    modport slave (
        input  cic_rate, cic_round, cic_din_valid, cic_din, cic_dout_ready,
        output cic_dout_valid, cic_dout, cic_ovf
    );
endinterface

// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator, differential delay M, run-time rate 2..R_MAX.
// Integrators run at the input rate, combs are pipelined one stage per
// cycle, and the result lands in a single-entry valid/ready output register
// with a sticky overwrite flag.
module cic_decimator_param #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int N     = 3,
    parameter int M     = 2,
    parameter int R_MAX = 32
) (
    input  logic                 cic_clk,
    input  logic                 cic_rst,
    cic_decimator_param_if.slave bus
);
    localparam int RATE_W = $clog2(R_MAX) + 1;
    localparam int ACC_W  = IN_W + N * $clog2(R_MAX * M);
    localparam int SH     = ACC_W - OUT_W;

    // Out-of-range rates are pulled into the supported 2..R_MAX window.
    function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
        if (r < RATE_W'(2))
            return RATE_W'(2);
        if (r > RATE_W'(R_MAX))
            return RATE_W'(R_MAX);
        return r;
    endfunction

    // Optional round-half-up, then keep the top OUT_W bits. Only a positive
    // overflow is possible (the bias is positive), so it clips to max.
    function automatic logic signed [OUT_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] x,
        input logic                    rnd
    );
        logic signed [ACC_W:0] bias;
        logic signed [ACC_W:0] s;
        bias         = '0;
        bias[SH-1]   = rnd;
        s            = {x[ACC_W-1], x} + bias;
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b0, {(OUT_W-1){1'b1}}};
        return s[ACC_W-1:SH];
    endfunction

    logic signed [ACC_W-1:0]  din_sx;
    logic signed [ACC_W-1:0]  integ     [N];
    logic signed [ACC_W-1:0]  integ_nxt [N];
    logic        [RATE_W-1:0] phase;
    logic        [RATE_W-1:0] r_act;
    logic                     dec;

    logic signed [ACC_W-1:0]  cap_p0;
    logic                     vld_p0;
    logic signed [ACC_W-1:0]  comb_in   [N];
    logic        [N-1:0]      comb_in_vld;
    logic signed [ACC_W-1:0]  comb_p    [N];
    logic        [N-1:0]      vld_p;
    logic signed [ACC_W-1:0]  dly       [N][M];

    logic signed [OUT_W-1:0]  dout_q;
    logic                     dout_vld;
    logic                     ovf_q;
    logic                     load;
    logic                     xfer;

    assign din_sx = {{(ACC_W-IN_W){bus.cic_din[IN_W-1]}}, bus.cic_din};
    assign dec    = bus.cic_din_valid && (phase == r_act - RATE_W'(1));

    // Integrator chain: each stage adds the freshly updated value of the one before.
    always_comb begin
        integ_nxt[0] = integ[0] + din_sx;
        for (int k = 1; k < N; k++)
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
    end

    // Integrator registers advance only on accepted samples; wrap is intended.
    always_ff @(posedge cic_clk) begin
        if (cic_rst) begin
            for (int k = 0; k < N; k++)
                integ[k] <= '0;
        end else if (bus.cic_din_valid) begin
            for (int k = 0; k < N; k++)
                integ[k] <= integ_nxt[k];
        end
    end

    // Frame counter; the rate is re-read only at a frame boundary.
    always_ff @(posedge cic_clk) begin
        if (cic_rst) begin
            phase <= '0;
            r_act <= clamp_rate(bus.cic_rate);
        end else if (bus.cic_din_valid) begin
            if (dec) begin
                phase <= '0;
                r_act <= clamp_rate(bus.cic_rate);
            end else begin
                phase <= phase + RATE_W'(1);
            end
        end
    end

    // ---- stage p0: capture the last integrator on the decimating sample ----
    always_ff @(posedge cic_clk) begin
        if (cic_rst) begin
            cap_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= dec;
            if (dec)
                cap_p0 <= integ_nxt[N-1];
        end
    end

    // Route each comb stage's input from the capture register or the previous comb.
    always_comb begin
        comb_in[0]     = cap_p0;
        comb_in_vld[0] = vld_p0;
        for (int k = 1; k < N; k++) begin
            comb_in[k]     = comb_p[k-1];
            comb_in_vld[k] = vld_p[k-1];
        end
    end

    // ---- stages p1..pN: one registered comb y = x - x[-M] per stage ----
    always_ff @(posedge cic_clk) begin
        if (cic_rst) begin
            vld_p <= '0;
            for (int k = 0; k < N; k++) begin
                comb_p[k] <= '0;
                for (int j = 0; j < M; j++)
                    dly[k][j] <= '0;
            end
        end else begin
            vld_p <= comb_in_vld;
            for (int k = 0; k < N; k++) begin
                if (comb_in_vld[k]) begin
                    comb_p[k] <= comb_in[k] - dly[k][M-1];
                    for (int j = M - 1; j > 0; j--)
                        dly[k][j] <= dly[k][j-1];
                    dly[k][0] <= comb_in[k];
                end
            end
        end
    end

    assign load = vld_p[N-1];
    assign xfer = dout_vld && bus.cic_dout_ready;

    // ---- output stage: single-entry holding register with overwrite flag ----
    always_ff @(posedge cic_clk) begin
        if (cic_rst) begin
            dout_q   <= '0;
            dout_vld <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            dout_q   <= round_sat(comb_p[N-1], bus.cic_round);
            dout_vld <= 1'b1;
            if (dout_vld && !bus.cic_dout_ready)
                ovf_q <= 1'b1;
        end else if (xfer) begin
            dout_vld <= 1'b0;
        end
    end

    assign bus.cic_dout       = dout_q;
    assign bus.cic_dout_valid = dout_vld;
    assign bus.cic_ovf        = ovf_q;
endmodule

// File: doc/cic_decimator_param.md
# cic_decimator_param

Parametrised N-stage CIC decimator with a differential delay of M and a decimation rate set at run time (2..R_MAX). It sits between the 8-bit sampled front end and the downstream FIR/compensation stage, and is the next generation of the fixed 3-stage, R=32 decimator. Over the fixed version it adds an input valid strobe, a pipelined comb section, optional round-half-up output scaling, and a valid/ready output handshake with a sticky overflow flag.

## Interface
- IN_W, 8, input sample width, two's complement
- OUT_W, 16, output sample width, two's complement
- N, 3, number of integrator and comb stages (1..6)
- M, 2, differential delay of each comb (1 or 2)
- R_MAX, 32, maximum decimation rate
- Derived, not overridable:
  - RATE_W = $clog2(R_MAX)+1
  - ACC_W = IN_W + N*$clog2(R_MAX*M)
  - SH = ACC_W − OUT_W
- cic_clk  in  1  clock; all logic on rising edge
- cic_rst  in  1  reset; synchronous, active-high
- cic_rate  in  RATE_W  decimation rate; sampled only at decimation boundaries
- cic_round  in  1  1 = round-half-up before truncation; 0 = truncate
- cic_din_valid  in  1  input sample strobe; always accepted (no input ready)
- cic_din  in  IN_W  input sample
- cic_dout_valid  out  1  output sample available
- cic_dout_ready  in  1  downstream accepts output when high together with valid
- cic_dout  out  OUT_W  decimated output sample
- cic_ovf  out  1  sticky flag: an unconsumed output sample was overwritten

## Operation
- **Integrators:** N ACC_W-bit accumulators in a combinational chain, all updated on the edge where cic_din_valid=1.
  - I0 += sxt(cic_din); Ik += Ik−1 (new value).
  - Arithmetic is modulo 2^ACC_W; wrap-around is intentional and required.
  - The registers hold their value when valid=0.
- **Rate counter:**
  - phase counts accepted samples from 0 to r_act−1.
  - When an accepted sample has phase==r_act−1, it is the decimating sample:
    - the comb capture register loads the new I(N−1) value;
    - phase returns to 0;
    - r_act reloads from cic_rate.
  - Clamp on load: cic_rate <2 gives 2; cic_rate >R_MAX gives R_MAX.
  - Rate changes therefore take effect only at the next decimation boundary and never split a frame.
- **Combs:** N stages. Stage k computes y = x − x[−M] and is registered.
  - Each stage has an M-deep delay line and a valid bit.
  - The delay line and output register advance only when the stage's input valid is 1.
  - The valid bit travels one stage per cycle.
- **Scaling:**
  - s = comb_out + (cic_round ? 2^(SH−1) : 0).
  - cic_dout = s[ACC_W−1:SH].
  - Positive overflow caused by rounding saturates to 2^(OUT_W−1)−1.
  - The gain is fixed to the R_MAX range. At lower rates the output is smaller by (R_MAX/r)^N; the downstream stage compensates.
- **Output register (one entry):**
  - Transfer occurs when valid & ready.
  - New comb result with the register empty, or being transferred this cycle: load and set valid.
  - New comb result with the register full and ready=0: overwrite the held sample, valid stays 1, cic_ovf ← 1.
  - Transfer with no new result: valid ← 0.
- **Reset values:**
  - All integrators, combs, delay lines and valid bits: 0.
  - phase 0; r_act = clamp(cic_rate) sampled during reset.
  - cic_dout 0, cic_dout_valid 0, cic_ovf 0.
  - Reset mid-frame discards the partial frame and any in-flight comb data; no output is produced from pre-reset samples.

## Timing
- **Latency:** the decimating sample is accepted at edge E. Capture happens at E, comb stages k=1..N at E+k, and the output register at E+N+1. cic_dout_valid is high in the cycle after edge E+N+1.
- **Throughput:** one input per cycle sustained. The output rate is ≤ 1/r_act of the input rate, so with ready held high no overflow is possible.
- **Settling:** the first N*M outputs after reset are transient (pipeline fill). Steady-state is reached from output index N*M onward.
- **Outputs are stable:** cic_dout and cic_dout_valid change only on a load, a transfer, or reset.
- **Simultaneous events:** a load and a transfer in the same cycle produce no ovf and leave valid at 1. cic_rst overrides everything.

## Test plan
All scenarios use the defaults (ACC_W=26, SH=10) unless stated.

- **DC positive:** din=1 on every cycle, rate=32, round=0, ready=1 → from output 6 onward cic_dout=256 every 32 inputs; ovf=0; first valid 4 cycles after the 32nd sample edge.
- **DC extremes:**
  - din=−128, rate 32 → steady dout=0x8000 (−32768).
  - din=127, rate 32 → 32512.
  - Integrators wrap internally with no effect on output.
- **Rate change and clamp:**
  - Switch cic_rate 32→16 mid-frame → the current frame completes at 32; the next frames use 16 and steady dout=32.
  - cic_rate=0 → behaves as rate 2.
  - cic_rate=63 → behaves as 32.
- **Rounding:** din=1, rate=20 → steady dout=62 with round=0; 63 with round=1.
- **Backpressure:**
  - Hold ready=0 across 3 outputs → valid stays 1, dout equals the 3rd output, ovf=1 and stays 1 after ready returns.
  - Same-cycle load+transfer → no ovf.
- **Reset mid-frame:** assert cic_rst for 1 cycle at phase 17 → next cycle all outputs are 0 and valid is 0. After release, outputs match a fresh run of the DC scenario exactly.
